// File: rtl/rx_uart.sv
// Oversampling UART receiver: 2-flop line synchronizer, mid-bit sampling FSM,
// and a registered word/status output with a one-clk valid pulse.
module rx_uart #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int PARITY_ENABLED   = 1,
  parameter int OVERSAMPLE       = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sample_tick,
  input  logic                        serial_in,
  output logic [INPUT_DATA_WIDTH-1:0] o_data,
  output logic                        o_valid,
  output logic                        o_parity_err,
  output logic                        o_framing_err,
  output logic                        o_busy
);

  // state  | meaning
  // IDLE   | line idle, waiting for a 0 on a tick
  // START  | counting to mid start bit to reject glitches
  // DATA   | sampling data bits, LSB first
  // PARITY | sampling the parity bit
  // STOP   | sampling the stop bit; result published one clk later
  // BREAK  | stop bit was 0, waiting for the line to return to 1
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(INPUT_DATA_WIDTH - 1);

  state_t                      state, state_d;
  logic   [TW-1:0]             tick_cnt, tick_d;
  logic   [BW-1:0]             bit_cnt, bit_d;
  logic   [INPUT_DATA_WIDTH-1:0] shift, shift_d;
  logic                        par_acc, par_d;
  logic                        stop_bit, stop_d;
  logic                        done, done_d;
  logic                        sync0, rx_s;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync0         <= 1'b1;
      rx_s          <= 1'b1;
      state         <= S_IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      par_acc       <= 1'b0;
      stop_bit      <= 1'b1;
      done          <= 1'b0;
      o_data        <= '0;
      o_valid       <= 1'b0;
      o_parity_err  <= 1'b0;
      o_framing_err <= 1'b0;
    end else begin
      sync0    <= serial_in;
      rx_s     <= sync0;
      state    <= state_d;
      tick_cnt <= tick_d;
      bit_cnt  <= bit_d;
      shift    <= shift_d;
      par_acc  <= par_d;
      stop_bit <= stop_d;
      done     <= done_d;
      o_valid  <= done;
      // shift/par_acc are untouched until the next START mid-sample, so they are still intact here
      if (done) begin
        o_data        <= shift;
        o_parity_err  <= (PARITY_ENABLED != 0) ? par_acc : 1'b0;
        o_framing_err <= ~stop_bit;
      end
    end
  end

  always_comb begin
    state_d = state;
    tick_d  = tick_cnt;
    bit_d   = bit_cnt;
    shift_d = shift;
    par_d   = par_acc;
    stop_d  = stop_bit;
    done_d  = 1'b0;
    if (sample_tick) begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end
        S_START: begin
          if (tick_cnt == TICK_MID) begin
            if (rx_s) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              tick_d  = '0;
              bit_d   = '0;
              par_d   = 1'b0;
            end
          end else begin
            tick_d = tick_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_cnt == TICK_LAST) begin
            tick_d = '0;
            shift_d = shift >> 1;
            shift_d[INPUT_DATA_WIDTH-1] = rx_s;
            par_d = par_acc ^ rx_s;
            if (bit_cnt == BIT_LAST)
              state_d = (PARITY_ENABLED != 0) ? S_PARITY : S_STOP;
            else
              bit_d = bit_cnt + 1'b1;
          end else begin
            tick_d = tick_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (tick_cnt == TICK_LAST) begin
            tick_d  = '0;
            par_d   = par_acc ^ rx_s;
            state_d = S_STOP;
          end else begin
            tick_d = tick_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tick_cnt == TICK_LAST) begin
            tick_d  = '0;
            stop_d  = rx_s;
            done_d  = 1'b1;
            state_d = rx_s ? S_IDLE : S_BREAK;
          end else begin
            tick_d = tick_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_rx_uart.sv
// Directed bench for rx_uart: fixed frames, break handling, glitch rejection,
// 256-word loopback and mid-frame reset, with one sample_tick per clk.
module tb_rx_uart;

  logic       clk = 1'b0;
  logic       reset, sample_tick, serial_in;
  logic [7:0] o_data;
  logic       o_valid, o_parity_err, o_framing_err, o_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int vcount  = 0;
  int last_cyc = 0;
  int v0, t0;
  logic [7:0] last_data;
  logic       last_pe, last_fe;
  logic [9:0] rxq[$];

  rx_uart #(.INPUT_DATA_WIDTH(8), .PARITY_ENABLED(1), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .serial_in(serial_in),
    .o_data(o_data), .o_valid(o_valid), .o_parity_err(o_parity_err),
    .o_framing_err(o_framing_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      vcount++;
      last_data = o_data;
      last_pe   = o_parity_err;
      last_fe   = o_framing_err;
      last_cyc  = cyc;
      rxq.push_back({o_framing_err, o_parity_err, o_data});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, output int ts);
    ts = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_data"},  32'(o_data), 32'h0);
    check({tag, "_valid"}, 32'(o_valid), 32'h0);
    check({tag, "_pe"},    32'(o_parity_err), 32'h0);
    check({tag, "_fe"},    32'(o_framing_err), 32'h0);
    check({tag, "_busy"},  32'(o_busy), 32'h0);
  endtask

  initial begin
    reset = 1'b0; sample_tick = 1'b1; serial_in = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 0xA5 with correct even parity; o_valid lands 172 clks after the start bit is driven
    v0 = vcount;
    send_frame(8'hA5, 1'b0, 1'b1, t0);
    repeat (10) @(negedge clk);
    check("a5_count",   32'(vcount - v0), 32'd1);
    check("a5_data",    32'(last_data), 32'hA5);
    check("a5_pe",      32'(last_pe), 32'h0);
    check("a5_fe",      32'(last_fe), 32'h0);
    check("a5_latency", 32'(last_cyc - t0), 32'd172);

    v0 = vcount;
    send_frame(8'h01, 1'b0, 1'b1, t0);
    repeat (10) @(negedge clk);
    check("par_count", 32'(vcount - v0), 32'd1);
    check("par_data",  32'(last_data), 32'h01);
    check("par_pe",    32'(last_pe), 32'h1);
    check("par_fe",    32'(last_fe), 32'h0);

    // stop bit 0 then line held low for 40 bit times
    v0 = vcount;
    send_frame(8'h3C, 1'b0, 1'b0, t0);
    repeat (640) @(negedge clk);
    check("brk_busy_low", 32'(o_busy), 32'h1);
    check("brk_count",    32'(vcount - v0), 32'd1);
    check("brk_data",     32'(last_data), 32'h3C);
    check("brk_pe",       32'(last_pe), 32'h0);
    check("brk_fe",       32'(last_fe), 32'h1);
    serial_in = 1'b1;
    repeat (5) @(negedge clk);
    check("brk_busy_idle", 32'(o_busy), 32'h0);
    v0 = vcount;
    send_frame(8'h55, 1'b0, 1'b1, t0);
    repeat (10) @(negedge clk);
    check("post_brk_count", 32'(vcount - v0), 32'd1);
    check("post_brk_data",  32'(last_data), 32'h55);
    check("post_brk_pe",    32'(last_pe), 32'h0);
    check("post_brk_fe",    32'(last_fe), 32'h0);

    // 4-clk low glitch in IDLE
    v0 = vcount;
    serial_in = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_hi", 32'(o_busy), 32'h1);
    serial_in = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_busy_lo", 32'(o_busy), 32'h0);
    repeat (20) @(negedge clk);
    check("glitch_count", 32'(vcount - v0), 32'd0);

    // back-to-back loopback with even parity
    rxq.delete();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] w;
      w = 8'(i);
      send_frame(w, ^w, 1'b1, t0);
    end
    repeat (20) @(negedge clk);
    check("loop_count", 32'(rxq.size()), 32'd256);
    for (int i = 0; i < 256; i++) begin
      if (i < rxq.size()) check("loop_word", 32'(rxq[i]), 32'(i));
    end

    // reset during data bit 4 of 0xFF
    v0 = vcount;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_zero_outputs("midrst");
    reset = 1'b1;
    repeat (40) @(negedge clk);
    send_frame(8'h81, 1'b0, 1'b1, t0);
    repeat (10) @(negedge clk);
    check("midrst_count", 32'(vcount - v0), 32'd1);
    check("midrst_data",  32'(last_data), 32'h81);
    check("midrst_pe",    32'(last_pe), 32'h0);
    check("midrst_fe",    32'(last_fe), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_uart.md
Name: rx_uart

Overview:
- Receive-side counterpart to the transmit serializer. Consumes its serial line (start 0, data LSB first, optional parity bit, stop 1) and rebuilds each frame.
- Oversamples the line using a tick strobe from the shared baud generator.
- Presents each received word with parity and framing status as a one-cycle valid pulse to the downstream consumer (FIFO or register interface).

Parameters:
- INPUT_DATA_WIDTH, 8, number of data bits per frame.
- PARITY_ENABLED, 1, 1 = one parity bit follows the data bits; 0 = none.
- OVERSAMPLE, 16, sample_tick pulses per bit period. Must be even and ≥4.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- sample_tick  input  1  one-clk strobe at OVERSAMPLE × baud rate.
- serial_in  input  1  asynchronous serial line, idles at 1.
- o_data  output  INPUT_DATA_WIDTH  last received data word, LSB = first data bit.
- o_valid  output  1  one-clk pulse when o_data and the error flags update.
- o_parity_err  output  1  parity mismatch on the last frame; valid while o_valid is high, held afterwards.
- o_framing_err  output  1  stop bit sampled 0 on the last frame; valid with o_valid, held afterwards.
- o_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset == 0 at a clk edge):
  - state = IDLE; counters = 0; synchronizer flops = 1.
  - o_data = 0; o_valid = 0; o_parity_err = 0; o_framing_err = 0; o_busy = 0.
  - Reset mid-frame discards the partial frame. No o_valid is issued for it.
- serial_in passes through a 2-flop synchronizer. All decisions use the synchronized value `rx_s`. Sampling happens only on clk edges where sample_tick = 1. No state changes between ticks except clearing o_valid.
- tick_cnt counts 0 to OVERSAMPLE-1. bit_cnt counts data bits.
- State machine:
  - IDLE: on a tick with rx_s == 0, go to START with tick_cnt = 0.
  - START: on the tick where tick_cnt == OVERSAMPLE/2-1 (mid-bit), sample rx_s.
    - If rx_s == 1 (glitch): return to IDLE with no output.
    - If rx_s == 0: tick_cnt = 0, bit_cnt = 0, go to DATA.
  - DATA: on each tick where tick_cnt == OVERSAMPLE-1, sample rx_s into the shift register (LSB first) and wrap tick_cnt to 0.
    - After INPUT_DATA_WIDTH samples: go to PARITY if PARITY_ENABLED, else STOP.
  - PARITY: sample after OVERSAMPLE ticks. Computed parity error = XOR of the data bits and the parity bit (even parity; error when the result is 1). Go to STOP.
  - STOP: sample after OVERSAMPLE ticks.
    - On the next clk: o_valid = 1 for exactly one clk; o_data = shift register; o_parity_err = computed error (0 if PARITY_ENABLED = 0); o_framing_err = !stop_sample.
    - If stop_sample == 1, go to IDLE.
    - If stop_sample == 0, go to BREAK.
  - BREAK: wait for a tick with rx_s == 1, then go to IDLE. A continuous 0 line yields exactly one framing-error word, never a stream of them.
- Latency: o_valid rises on the clk edge after the stop-bit sample tick. Sample points are OVERSAMPLE/2 ticks into each bit, ±1 tick for synchronizer and edge-detect skew.
- Back-to-back frames: a new start edge seen on the first IDLE tick after STOP is accepted. No inter-frame gap is required beyond one stop bit.
- o_data and the error flags hold their value until the next o_valid. No backpressure; the consumer must take the word within one frame time.
- sample_tick held at 0: the FSM freezes in its current state, and o_valid still deasserts after one clk.

Test Plan:
- Byte 0xA5, parity 0, stop 1, OVERSAMPLE = 16, one tick per clk. Line sequence 0,1,0,1,0,0,1,0,1,0,1 → exactly one o_valid; o_data = 0xA5, o_parity_err = 0, o_framing_err = 0; o_valid arrives 1 clk after the stop-bit sample.
- Byte 0x01 sent with parity bit 0 (wrong) → o_data = 0x01, o_parity_err = 1, o_framing_err = 0.
- Byte 0x3C with stop bit forced 0, then the line held 0 for 40 bit times → exactly one o_valid with o_framing_err = 1; o_busy stays high until the line returns to 1; the following frame 0x55 is received clean.
- 0-pulse of 4 ticks while IDLE → no o_valid, o_busy returns to 0 within 8 ticks.
- Serializer-to-receiver loopback, 256 words 0x00–0xFF back-to-back, even parity generated at the source → 256 o_valid pulses, data matches in order, no error flags.
- reset driven 0 for one clk during data bit 4 of 0xFF, then frame 0x81 sent → no word for 0xFF; o_data = 0x81, flags 0; all outputs 0 in the cycle after reset.
